// File: rtl/io_scan_pkg.sv
// Shared types and width helpers for the expansion-board I/O scanner.
package io_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  typedef enum logic {
    PH_WRITE,
    PH_READ
  } phase_e;

  function automatic int enable_count(input int boards, input int slots_per_enable);
    return boards / slots_per_enable;
  endfunction

  // {dir, slot within its enable group}
  function automatic int addr_width(input int slots_per_enable);
    return 1 + $clog2(slots_per_enable);
  endfunction

  function automatic int timer_width(input int setup, input int strobe, input int hold);
    int longest;
    longest = setup;
    if (strobe > longest) longest = strobe;
    if (hold > longest) longest = hold;
    return $clog2(longest + 1);
  endfunction

  function automatic int slot_width(input int boards);
    return (boards > 1) ? $clog2(boards) : 1;
  endfunction

endpackage

// File: rtl/io_phase_timer.sv
// Loadable down-counter that times one bus phase; done while the count sits at zero.
module io_phase_timer #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/io_scan_controller.sv
// Scans installed I/O slots over the multiplexed bus: write then read per slot,
// with the sampled bytes published atomically at the end of each frame.
module io_scan_controller
  import io_scan_pkg::*;
#(
  parameter int BOARDS           = 16,
  parameter int INSTALLED_BOARDS = 2,
  parameter int DATA_WIDTH       = 8,
  parameter int SLOTS_PER_ENABLE = 8,
  parameter int SETUP_CYCLES     = 1,
  parameter int STROBE_CYCLES    = 1,
  parameter int HOLD_CYCLES      = 1
) (
  input  logic                                            Clk,
  input  logic                                            Rst_n,
  input  logic                                            run,
  input  logic [BOARDS*DATA_WIDTH-1:0]                    outputs,
  output logic [BOARDS*DATA_WIDTH-1:0]                    inputs,
  output logic [BOARDS-1:0]                               inputs_changed,
  output logic                                            frame_done,
  output logic [addr_width(SLOTS_PER_ENABLE)-1:0]         io_address,
  output logic [enable_count(BOARDS, SLOTS_PER_ENABLE)-1:0] io_enable_n,
  output logic [DATA_WIDTH-1:0]                           io_data_o,
  output logic                                            io_data_oe,
  input  logic [DATA_WIDTH-1:0]                           io_data_i
);

  localparam int ENABLES = enable_count(BOARDS, SLOTS_PER_ENABLE);
  localparam int SAW     = $clog2(SLOTS_PER_ENABLE);
  localparam int TW      = timer_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int SLOT_W  = slot_width(BOARDS);

  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(INSTALLED_BOARDS - 1);
  localparam logic [TW-1:0]     SETUP_LOAD  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0]     STROBE_LOAD = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0]     HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  stop_q;
  logic                  timer_load, timer_done;
  logic [TW-1:0]         timer_value;
  logic                  latch_write, capture, publish;
  logic [DATA_WIDTH-1:0] out_slot [BOARDS];
  logic [DATA_WIDTH-1:0] shadow   [BOARDS];

  for (genvar s = 0; s < BOARDS; s++) begin : g_unpack
    assign out_slot[s] = outputs[s*DATA_WIDTH +: DATA_WIDTH];
  end

  io_phase_timer #(.WIDTH(TW)) u_timer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    slot_d      = slot_q;
    timer_load  = 1'b0;
    timer_value = SETUP_LOAD;
    latch_write = 1'b0;
    capture     = 1'b0;
    publish     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_SETUP;
          phase_d     = PH_WRITE;
          slot_d      = '0;
          timer_load  = 1'b1;
          latch_write = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_d     = ST_STROBE;
          timer_load  = 1'b1;
          timer_value = STROBE_LOAD;
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          state_d     = ST_HOLD;
          timer_load  = 1'b1;
          timer_value = HOLD_LOAD;
          capture     = (phase_q == PH_READ);
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          state_d    = ST_SETUP;
          timer_load = 1'b1;
          if (phase_q == PH_WRITE) begin
            phase_d = PH_READ;
          end else begin
            phase_d     = PH_WRITE;
            latch_write = 1'b1;
            if (slot_q != LAST_SLOT) begin
              slot_d = slot_q + SLOT_W'(1);
            end else begin
              // Frame boundary: publish, then restart or park depending on run.
              publish = 1'b1;
              slot_d  = '0;
              if (!run || stop_q) begin
                state_d     = ST_IDLE;
                timer_load  = 1'b0;
                latch_write = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_WRITE;
      slot_q         <= '0;
      stop_q         <= 1'b0;
      io_data_o      <= '0;
      inputs         <= '0;
      inputs_changed <= '0;
      frame_done     <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      slot_q         <= slot_d;
      // A low run seen anywhere in a frame ends scanning after that frame.
      stop_q         <= (state_q != ST_IDLE) && (stop_q || !run);
      frame_done     <= publish;
      inputs_changed <= '0;
      if (latch_write) io_data_o <= out_slot[slot_d];
      if (publish) begin
        for (int s = 0; s < INSTALLED_BOARDS; s++) begin
          inputs[s*DATA_WIDTH +: DATA_WIDTH] <= shadow[s];
          inputs_changed[s] <= (shadow[s] != inputs[s*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // NOTE: shadow is deliberately not reset: every installed entry is rewritten
  // during a frame before it can be published, and reset aborts the frame.
  always_ff @(posedge Clk) begin
    if (capture) shadow[slot_q] <= io_data_i;
  end

  always_comb begin
    io_enable_n = '1;
    for (int e = 0; e < ENABLES; e++) begin
      if (state_q == ST_STROBE && (int'(slot_q) / SLOTS_PER_ENABLE) == e) io_enable_n[e] = 1'b0;
    end
  end

  assign io_address = (state_q == ST_IDLE) ? '0 : {phase_q == PH_WRITE, slot_q[SAW-1:0]};
  assign io_data_oe = (state_q != ST_IDLE) && (phase_q == PH_WRITE);

endmodule

// File: tb/tb_io_scan_controller.sv
// Scoreboard bench: three scanner configurations driven from a frame-level model.
module tb_io_scan_controller;

  localparam int NI = 3;
  localparam int CFG_N [NI] = '{2, 2, 16};
  localparam int CFG_S [NI] = '{1, 2, 1};
  localparam int CFG_T [NI] = '{1, 3, 1};
  localparam int CFG_H [NI] = '{1, 1, 1};

  typedef struct packed {
    logic       acc;
    logic [3:0] addr;
    logic [1:0] en_n;
    logic       oe;
    logic [7:0] data;
    logic       done;
  } bus_t;

  localparam bus_t IDLE_E = '{acc: 1'b0, addr: 4'h0, en_n: 2'b11, oe: 1'b0, data: 8'h00, done: 1'b0};

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         run          [NI];
  logic [127:0] outputs_v    [NI];
  logic [127:0] inputs_v     [NI];
  logic [15:0]  changed_v    [NI];
  logic         frame_done_v [NI];
  logic [3:0]   addr_v       [NI];
  logic [1:0]   en_v         [NI];
  logic [7:0]   dato_v       [NI];
  logic [7:0]   dati_v       [NI];
  logic         oe_v         [NI];

  logic [127:0] dev_v [NI];
  logic [127:0] pub_v [NI];
  bus_t         bus_q [NI][$];
  logic [143:0] pub_q [NI][$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    io_scan_controller #(
      .BOARDS          (16),
      .INSTALLED_BOARDS(CFG_N[g]),
      .DATA_WIDTH      (8),
      .SLOTS_PER_ENABLE(8),
      .SETUP_CYCLES    (CFG_S[g]),
      .STROBE_CYCLES   (CFG_T[g]),
      .HOLD_CYCLES     (CFG_H[g])
    ) u_dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .run           (run[g]),
      .outputs       (outputs_v[g]),
      .inputs        (inputs_v[g]),
      .inputs_changed(changed_v[g]),
      .frame_done    (frame_done_v[g]),
      .io_address    (addr_v[g]),
      .io_enable_n   (en_v[g]),
      .io_data_o     (dato_v[g]),
      .io_data_oe    (oe_v[g]),
      .io_data_i     (dati_v[g])
    );

    always @(negedge Clk) begin
      bus_t exp_e, act_e;
      if (mon_en) begin
        if (bus_q[g].size() > 0) exp_e = bus_q[g].pop_front();
        else exp_e = IDLE_E;
        act_e.acc  = exp_e.acc;
        act_e.addr = exp_e.acc ? addr_v[g] : 4'h0;
        act_e.en_n = en_v[g];
        act_e.oe   = oe_v[g];
        act_e.data = exp_e.oe ? dato_v[g] : 8'h00;
        act_e.done = frame_done_v[g];
        check($sformatf("bus%0d", g), 160'(act_e), 160'(exp_e));
        if (frame_done_v[g] === 1'b1) begin
          if (pub_q[g].size() > 0) begin
            check($sformatf("publish%0d", g), 160'({inputs_v[g], changed_v[g]}), 160'(pub_q[g].pop_front()));
          end else begin
            total++;
            bad++;
            $display("FAIL publish%0d: got unexpected frame_done, required none", g);
          end
        end
      end
    end
  end

  // Runs nfr back-to-back frames on instance k; the model is the access list
  // write(s), read(s) for each installed slot, each S+T+H cycles long.
  task automatic run_frames(input int k, input int nfr, input bit rnd, input int drop_at, input int rst_at);
    int n, s_c, t_c, a, len, dc, slot, c;
    bit wr;
    logic [7:0] wdata;
    logic [15:0] chg;
    bus_t e;
    n     = CFG_N[k];
    s_c   = CFG_S[k];
    t_c   = CFG_T[k];
    a     = s_c + t_c + CFG_H[k];
    len   = 2 * n * a;
    dc    = (drop_at < 0) ? len - 1 : drop_at;
    wdata = 8'h00;
    run[k] = 1'b1;
    @(posedge Clk); #1;
    for (int f = 0; f < nfr; f++) begin
      if (rnd) begin
        for (int s = 0; s < n; s++)
          if ($urandom_range(3) != 0) dev_v[k][s*8 +: 8] = 8'($urandom);
      end
      chg = '0;
      for (int s = 0; s < n; s++) chg[s] = (dev_v[k][s*8 +: 8] != pub_v[k][s*8 +: 8]);
      pub_v[k] = dev_v[k];
      pub_q[k].push_back({pub_v[k], chg});
      for (int cyc = 0; cyc < len; cyc++) begin
        slot = cyc / (2 * a);
        wr   = ((cyc / a) % 2) == 0;
        c    = cyc % a;
        if (wr && c == 0) wdata = outputs_v[k][slot*8 +: 8];
        e.acc  = 1'b1;
        e.addr = {wr, 3'(slot % 8)};
        e.en_n = (c >= s_c && c < s_c + t_c) ? ~(2'b01 << (slot / 8)) : 2'b11;
        e.oe   = wr;
        e.data = wr ? wdata : 8'h00;
        e.done = (f > 0 && cyc == 0);
        bus_q[k].push_back(e);
        // Device presents its byte only in the final strobe cycle; junk otherwise.
        dati_v[k] = (!wr && c == s_c + t_c - 1) ? dev_v[k][slot*8 +: 8] : ~dev_v[k][slot*8 +: 8];
        if (wr && c == 0) outputs_v[k][slot*8 +: 8] = 8'($urandom);
        if (f == nfr - 1 && cyc == dc) run[k] = 1'b0;
        if (cyc == rst_at) begin
          Rst_n  = 1'b0;
          run[k] = 1'b0;
          @(posedge Clk); #1;
          for (int j = 0; j < NI; j++) begin
            pub_v[j] = '0;
            bus_q[j].delete();
            pub_q[j].delete();
          end
          check("reset_abort", 160'({inputs_v[k], changed_v[k], frame_done_v[k]}), 160'(0));
          Rst_n = 1'b1;
          repeat (4) @(posedge Clk);
          #1;
          return;
        end
        @(posedge Clk); #1;
      end
    end
    e = IDLE_E;
    e.done = 1'b1;
    bus_q[k].push_back(e);
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      run[k]       = 1'b0;
      outputs_v[k] = '0;
      dati_v[k]    = '0;
      dev_v[k]     = '0;
      pub_v[k]     = '0;
    end
    repeat (3) @(posedge Clk);
    #1;
    mon_en = 1'b1;
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_regs%0d", k), 160'({inputs_v[k], changed_v[k], frame_done_v[k]}), 160'(0));
    Rst_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;

    // Default timing, known bytes, then an identical second frame.
    outputs_v[0][7:0]  = 8'hA5;
    outputs_v[0][15:8] = 8'h3C;
    dev_v[0][7:0]      = 8'h11;
    dev_v[0][15:8]     = 8'h22;
    run_frames(0, 2, 1'b0, -1, -1);
    run_frames(0, 4, 1'b1, -1, -1);
    // run dropped during slot 0 write strobe
    run_frames(0, 1, 1'b1, CFG_S[0], -1);
    // Stretched setup/strobe timing
    run_frames(1, 3, 1'b1, -1, -1);
    // All sixteen slots: second enable group and slot wrap
    run_frames(2, 2, 1'b1, -1, -1);
    // Reset during the slot 1 read strobe
    run_frames(0, 1, 1'b1, -1, 3 * (CFG_S[0] + CFG_T[0] + CFG_H[0]) + CFG_S[0]);
    run_frames(1, 1, 1'b1, -1, -1);
    run_frames(0, 2, 1'b1, -1, -1);

    for (int k = 0; k < NI; k++)
      check($sformatf("drain%0d", k), 160'(bus_q[k].size() + pub_q[k].size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
